// File: rtl/vdp_host_pkg.sv
// rtl/vdp_host_pkg.sv - shared types and helpers for the VDP host-bus front end
package vdp_host_pkg;

    localparam int VDP_ADR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_HOLD,
        RD_HOLD,
        RD_CAP,
        WAIT_REL
    } host_state_t;

    // TI numbers bit 0 as the MSB; the VDP core numbers bit 7 as the MSB.
    function automatic logic [7:0] bit_rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/vdp_host_if_if.sv
// rtl/vdp_host_if_if.sv - host pin and VDP CPU-port signal bundle
interface vdp_host_bus;
    import vdp_host_pkg::*;

    logic                 csr_n;
    logic                 csw_n;
    logic [1:0]           mode;
    logic [7:0]           cd_i;
    logic                 cpu_req;
    logic                 cpu_wrt;
    logic [VDP_ADR_W-1:0] cpu_adr;
    logic [7:0]           cpu_dbo;
    logic [7:0]           vdp_dbi;
    logic [7:0]           cd_o;
    logic                 cd_oe;
    logic                 err_both;
    logic                 err_clr;

    modport master (
        output csr_n, csw_n, mode, cd_i, vdp_dbi, err_clr,
        input  cpu_req, cpu_wrt, cpu_adr, cpu_dbo, cd_o, cd_oe, err_both
    );

    modport slave (
        input  csr_n, csw_n, mode, cd_i, vdp_dbi, err_clr,
        output cpu_req, cpu_wrt, cpu_adr, cpu_dbo, cd_o, cd_oe, err_both
    );

endinterface

// File: rtl/vdp_host_if_strobe_filter.sv
// rtl/vdp_host_if_strobe_filter.sv - one-bit synchroniser plus consecutive-sample deglitcher
module strobe_filter #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 3,
    parameter logic IDLE_LVL    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] vld;
    logic                   armed;
    logic [CW-1:0]          cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // A strobe held active through reset must be seen idle once before it may
    // leave the idle level, so a stale access never turns into a request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= {SYNC_STAGES{IDLE_LVL}};
            vld   <= '0;
            armed <= 1'b0;
            cnt   <= '0;
            dout  <= IDLE_LVL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            vld  <= {vld[SYNC_STAGES-2:0], 1'b1};
            if (vld[SYNC_STAGES-1] && (s == IDLE_LVL)) begin
                armed <= 1'b1;
            end
            if ((s == dout) || ((s != IDLE_LVL) && !armed)) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_CYCLES - 1)) begin
                dout <= s;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vdp_host_if.sv
// rtl/vdp_host_if.sv - host-bus front end issuing one VDP request per filtered strobe access
module vdp_host_if
    import vdp_host_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_CYCLES    = 3,
    parameter int RD_CAPTURE_DLY = 4
) (
    input logic       clk,
    input logic       reset,
    vdp_host_bus.slave bus
);

    localparam int CCW = $clog2(RD_CAPTURE_DLY + 1);

    logic                        f_rd_n;
    logic                        f_wr_n;
    logic [SYNC_STAGES-1:0][1:0] mode_sync;
    logic [SYNC_STAGES-1:0][7:0] cd_sync;
    logic [1:0]                  mode_s;
    logic [7:0]                  cd_s;
    host_state_t                 state;
    logic [CCW-1:0]              cap_cnt;
    logic [7:0]                  rd_data;

    strobe_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES),
        .IDLE_LVL   (1'b1)
    ) u_rd_filt (
        .clk  (clk),
        .reset(reset),
        .din  (bus.csr_n),
        .dout (f_rd_n)
    );

    strobe_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES),
        .IDLE_LVL   (1'b1)
    ) u_wr_filt (
        .clk  (clk),
        .reset(reset),
        .din  (bus.csw_n),
        .dout (f_wr_n)
    );

    // Mode and data are stable well before the filtered strobe arrives, so no deglitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_sync <= '0;
            cd_sync   <= '0;
        end else begin
            mode_sync <= {mode_sync[SYNC_STAGES-2:0], bus.mode};
            cd_sync   <= {cd_sync[SYNC_STAGES-2:0], bus.cd_i};
        end
    end

    assign mode_s    = mode_sync[SYNC_STAGES-1];
    assign cd_s      = cd_sync[SYNC_STAGES-1];
    assign bus.cd_o  = bit_rev8(rd_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cap_cnt      <= '0;
            rd_data      <= '0;
            bus.cpu_req  <= 1'b0;
            bus.cpu_wrt  <= 1'b0;
            bus.cpu_adr  <= '0;
            bus.cpu_dbo  <= '0;
            bus.cd_oe    <= 1'b0;
            bus.err_both <= 1'b0;
        end else begin
            bus.cpu_req <= 1'b0;
            bus.cd_oe   <= !f_rd_n && f_wr_n && (state != WAIT_REL);
            // Any set of err_both below overrides this clear.
            if (bus.err_clr) begin
                bus.err_both <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!f_wr_n && !f_rd_n) begin
                        bus.err_both <= 1'b1;
                        state        <= WAIT_REL;
                    end else if (!f_wr_n) begin
                        bus.cpu_req <= 1'b1;
                        bus.cpu_wrt <= 1'b1;
                        bus.cpu_adr <= {{(VDP_ADR_W-2){1'b0}}, mode_s};
                        bus.cpu_dbo <= bit_rev8(cd_s);
                        state       <= WR_HOLD;
                    end else if (!f_rd_n) begin
                        bus.cpu_req <= 1'b1;
                        bus.cpu_wrt <= 1'b0;
                        bus.cpu_adr <= {{(VDP_ADR_W-2){1'b0}}, mode_s};
                        cap_cnt     <= CCW'(RD_CAPTURE_DLY);
                        state       <= RD_CAP;
                    end
                end
                RD_CAP: begin
                    if (cap_cnt == CCW'(1)) begin
                        rd_data <= bus.vdp_dbi;
                        cap_cnt <= '0;
                        state   <= f_rd_n ? IDLE : RD_HOLD;
                    end else begin
                        cap_cnt <= cap_cnt - CCW'(1);
                    end
                end
                WR_HOLD: begin
                    if (f_wr_n) begin
                        state <= IDLE;
                    end else if (!f_rd_n) begin
                        bus.err_both <= 1'b1;
                        state        <= WAIT_REL;
                    end
                end
                RD_HOLD: begin
                    if (f_rd_n) begin
                        state <= IDLE;
                    end else if (!f_wr_n) begin
                        bus.err_both <= 1'b1;
                        state        <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (f_rd_n && f_wr_n) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_host_if.sv
// tb/tb_vdp_host_if.sv - directed bench with a transaction-level model of the host front end
module tb_vdp_host_if;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    vdp_host_bus bus();

    vdp_host_if #(
        .SYNC_STAGES   (2),
        .FILT_CYCLES   (3),
        .RD_CAPTURE_DLY(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         wrt;
        logic [15:0] adr;
        logic [7:0]  dbo;
        logic [7:0]  dbi;
        int          fall;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       ce;
    logic [7:0] m_rd = 8'h00;
    logic [7:0] cap_val = 8'h00;
    int         cap_at = -1;
    bit         prev_req = 1'b0;
    bit         rd_armed = 1'b0;
    int         req_total = 0;
    int         lat;
    int         rd_chg = 0;
    int         wr_chg = 0;
    int         base;
    logic [7:0] bb_data [8] = '{8'h01, 8'h02, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'hC3, 8'h7E};

    function automatic logic [7:0] rev(input logic [7:0] x);
        logic [7:0] r;
        r = {<<{x}};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit w, input logic [15:0] a, input logic [7:0] d, input logic [7:0] dbi);
        exp_t e;
        e.wrt  = w;
        e.adr  = a;
        e.dbo  = d;
        e.dbi  = dbi;
        e.fall = cyc;
        exp_q.push_back(e);
    endtask

    task automatic set_rd(input logic v);
        bus.csr_n = v;
        rd_chg    = cyc;
    endtask

    task automatic set_wr(input logic v);
        bus.csw_n = v;
        wr_chg    = cyc;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, bus.cpu_req, 0);
        check({tag, "_wrt"}, bus.cpu_wrt, 0);
        check({tag, "_adr"}, bus.cpu_adr, 0);
        check({tag, "_dbo"}, bus.cpu_dbo, 0);
        check({tag, "_cd_o"}, bus.cd_o, 0);
        check({tag, "_cd_oe"}, bus.cd_oe, 0);
        check({tag, "_err"}, bus.err_both, 0);
    endtask

    // Every cycle: requests against the queue of accesses, read data, and pin enable.
    always @(negedge clk) begin
        if (reset) begin
            m_rd     = 8'h00;
            cap_at   = -1;
            prev_req = 1'b0;
            rd_armed = 1'b0;
        end else begin
            if (bus.csr_n) rd_armed = 1'b1;
            if (bus.cpu_req) begin
                req_total++;
                check("req_consec", prev_req, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_unexpected actual=req required=none cycle=%0d", cyc);
                end else begin
                    ce = exp_q.pop_front();
                    check("req_wrt", bus.cpu_wrt, ce.wrt);
                    check("req_adr", bus.cpu_adr, ce.adr);
                    if (ce.wrt) begin
                        check("req_dbo", bus.cpu_dbo, ce.dbo);
                    end else begin
                        cap_at  = cyc + 4;
                        cap_val = ce.dbi;
                    end
                    lat = cyc - ce.fall;
                    checks++;
                    if (lat < 5 || lat > 7) begin
                        failures++;
                        $display("FAIL req_latency actual=%0d required=5..7", lat);
                    end
                end
            end
            prev_req = bus.cpu_req;
            if (cyc == cap_at) m_rd = cap_val;
            check("cd_o", bus.cd_o, rev(m_rd));
            if ((cyc - rd_chg >= 8) && (cyc - wr_chg >= 8)) begin
                check("cd_oe", bus.cd_oe, !bus.csr_n && rd_armed && bus.csw_n);
            end
        end
    end

    initial begin
        bus.csr_n   = 1'b1;
        bus.csw_n   = 1'b1;
        bus.mode    = 2'b00;
        bus.cd_i    = 8'h00;
        bus.vdp_dbi = 8'h00;
        bus.err_clr = 1'b0;
        reset       = 1'b1;
        wait_cyc(3);
        check_reset_vals("rst");
        reset  = 1'b0;
        rd_chg = cyc;
        wr_chg = cyc;
        wait_cyc(10);

        // Single write
        base     = req_total;
        bus.mode = 2'b01;
        bus.cd_i = 8'h81;
        push(1'b1, 16'h0001, 8'h81, 8'h00);
        set_wr(1'b0);
        wait_cyc(20);
        set_wr(1'b1);
        wait_cyc(12);
        check("wr_count", req_total - base, 1);
        check("wr_dbo_hold", bus.cpu_dbo, 8'h81);

        // Single read
        base        = req_total;
        bus.mode    = 2'b00;
        bus.vdp_dbi = 8'h0F;
        push(1'b0, 16'h0000, 8'h00, 8'h0F);
        set_rd(1'b0);
        wait_cyc(12);
        check("rd_cd_o", bus.cd_o, 8'hF0);
        check("rd_oe_on", bus.cd_oe, 1);
        wait_cyc(8);
        set_rd(1'b1);
        wait_cyc(4);
        check("rd_oe_hold", bus.cd_oe, 1);
        wait_cyc(4);
        check("rd_oe_off", bus.cd_oe, 0);
        wait_cyc(4);
        check("rd_count", req_total - base, 1);

        // Glitches: 2 cycles rejected, 3 cycles accepted
        base = req_total;
        set_wr(1'b0);
        wait_cyc(2);
        set_wr(1'b1);
        wait_cyc(15);
        check("glitch2_count", req_total - base, 0);
        bus.mode = 2'b10;
        bus.cd_i = 8'h40;
        push(1'b1, 16'h0002, 8'h02, 8'h00);
        set_wr(1'b0);
        wait_cyc(3);
        set_wr(1'b1);
        wait_cyc(15);
        check("glitch3_count", req_total - base, 1);

        // Simultaneous strobes
        base = req_total;
        set_rd(1'b0);
        set_wr(1'b0);
        wait_cyc(15);
        check("both_err", bus.err_both, 1);
        check("both_noreq", req_total - base, 0);
        set_rd(1'b1);
        set_wr(1'b1);
        wait_cyc(15);
        check("both_err_sticky", bus.err_both, 1);
        bus.mode = 2'b10;
        bus.cd_i = 8'h12;
        push(1'b1, 16'h0002, 8'h48, 8'h00);
        set_wr(1'b0);
        wait_cyc(12);
        set_wr(1'b1);
        wait_cyc(12);
        check("both_next_ok", req_total - base, 1);
        bus.err_clr = 1'b1;
        wait_cyc(1);
        bus.err_clr = 1'b0;
        check("err_clr", bus.err_both, 0);

        // Back-to-back writes
        base = req_total;
        for (int i = 0; i < 8; i++) begin
            bus.mode = 2'(i % 4);
            bus.cd_i = bb_data[i];
            push(1'b1, 16'(i % 4), rev(bb_data[i]), 8'h00);
            set_wr(1'b0);
            wait_cyc(10);
            set_wr(1'b1);
            wait_cyc(10);
        end
        wait_cyc(5);
        check("b2b_count", req_total - base, 8);
        check("b2b_dbo_last", bus.cpu_dbo, 8'h7E);

        // Reset in the middle of a read capture
        base        = req_total;
        bus.mode    = 2'b11;
        bus.vdp_dbi = 8'h3C;
        push(1'b0, 16'h0003, 8'h00, 8'h3C);
        set_rd(1'b0);
        wait_cyc(8);
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        wait_cyc(2);
        reset  = 1'b0;
        rd_chg = cyc;
        wr_chg = cyc;
        wait_cyc(20);
        check("midrst_noreq", req_total - base, 1);
        check("midrst_oe", bus.cd_oe, 0);
        set_rd(1'b1);
        wait_cyc(10);
        bus.vdp_dbi = 8'h1E;
        push(1'b0, 16'h0003, 8'h00, 8'h1E);
        set_rd(1'b0);
        wait_cyc(20);
        check("midrst_cd_o", bus.cd_o, 8'h78);
        set_rd(1'b1);
        wait_cyc(12);
        check("midrst_count", req_total - base, 2);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vdp_host_if.md
Name: vdp_host_if

Overview:
- Host-bus front end between the TI-style CPU bus pins (csr_n, csw_n, mode[1:0], cd[0:7]) and the VDP core's CPU port (REQ/WRT/ADR/DBO/DBI).
- Synchronises and deglitches the asynchronous strobes, and issues exactly one single-cycle VDP request per bus access.
- Captures VDP read data and presents it bit-reversed to the pin driver.
- Replaces the ad-hoc strobe sync and io_state logic at the top level, and runs in the VDP clock domain.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchroniser chain (minimum 2).
- FILT_CYCLES, 3, consecutive equal synchronised samples required before a filtered strobe changes (minimum 1).
- RD_CAPTURE_DLY, 4, cycles from the read-request pulse to the capture of vdp_dbi (minimum 1).

Ports:
- clk  in  1  VDP clock (21.477 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- csr_n  in  1  raw host read strobe, asynchronous.
- csw_n  in  1  raw host write strobe, asynchronous.
- mode  in  2  raw host register select, asynchronous.
- cd_i  in  8  raw host data bus; cd_i[0] is the MSB (TI ordering).
- cpu_req  out  1  one-cycle VDP request.
- cpu_wrt  out  1  1 = write, 0 = read; meaningful only while cpu_req = 1.
- cpu_adr  out  16  {14'b0, mode latched at the request}.
- cpu_dbo  out  8  write data, bit-reversed so that bit 7 is the MSB.
- vdp_dbi  in  8  VDP read data (bit 7 is the MSB).
- cd_o  out  8  read data for the pins, TI ordering (cd_o[0] = rd_data[7]).
- cd_oe  out  1  pin driver enable.
- err_both  out  1  sticky flag: both strobes were seen active together.
- err_clr  in  1  synchronous clear for err_both.

Behaviour:
- Reset values:
  - all synchroniser and filter flops reset to the idle level (strobes 1, other inputs 0);
  - filter counters 0;
  - state IDLE;
  - cpu_req 0, cpu_wrt 0, cpu_adr 0, cpu_dbo 0;
  - rd_data 0, cd_oe 0, err_both 0.
- Synchronisers: csr_n, csw_n, mode and cd_i each pass through a SYNC_STAGES chain.
- Filter on each strobe: the filtered value f_rd_n / f_wr_n takes the synchronised value once it has differed from the current filtered value for FILT_CYCLES consecutive cycles. Any return to the old value resets the counter to 0.
- Latency from a raw strobe edge to the cpu_req pulse is SYNC_STAGES + FILT_CYCLES + 1 cycles: 6 with the defaults, ±1 for metastability resolution.
- FSM states: IDLE, WR_HOLD, RD_HOLD, RD_CAP, WAIT_REL.
  - IDLE, f_wr_n = 0 and f_rd_n = 1: pulse cpu_req for 1 cycle with cpu_wrt = 1; cpu_adr and cpu_dbo latch the synchronised mode/cd_i in the same cycle; go to WR_HOLD.
  - IDLE, f_rd_n = 0 and f_wr_n = 1: pulse cpu_req with cpu_wrt = 0; latch cpu_adr; load the capture counter with RD_CAPTURE_DLY; go to RD_CAP.
  - IDLE, both strobes 0 in the same cycle: no request; set err_both; go to WAIT_REL.
  - RD_CAP: the counter decrements each cycle. When it reaches 0, rd_data <= vdp_dbi and the FSM goes to RD_HOLD. If f_rd_n rises before capture, the capture still completes and the FSM then goes to IDLE.
  - WR_HOLD / RD_HOLD: when the own filtered strobe returns to 1, go to IDLE. If the opposite strobe goes to 0 first, set err_both and go to WAIT_REL.
  - WAIT_REL: stay until both filtered strobes are 1, then go to IDLE. No request is ever issued from this state.
- cpu_req is never high on two consecutive cycles, and never more than once per filtered strobe-low interval.
- cpu_adr and cpu_dbo hold their values between requests.
- cd_oe is registered: it is 1 when f_rd_n = 0, f_wr_n = 1 and state is not WAIT_REL; otherwise 0.
- cd_o = bit-reverse(rd_data). Before the first capture of an access, cd_o shows the previous read's data.
- err_both: setting takes priority over err_clr when both occur in the same cycle.
- Reset asserted mid-access: everything returns to its reset value immediately. After release, a strobe that is still low does not generate a request until it has gone high and low again, because the filter starts from the idle level and the FSM requires IDLE with a fresh filtered edge.

Decomposition:
- Package vdp_host_pkg holds:
  - the state enum (IDLE, WR_HOLD, RD_HOLD, RD_CAP, WAIT_REL);
  - the bit-reverse function;
  - the constant VDP_ADR_W = 16.
- One sub-module, strobe_filter: the parameterised synchroniser plus FILT_CYCLES deglitcher for one bit, with an idle-level parameter. It is instantiated twice, for csr_n and csw_n.
- mode and cd_i use plain synchroniser chains, with no filter.

Test Plan:
- Write: mode = 2'b01, cd_i = 8'h81 (TI order, so cpu_dbo = 8'h81 reversed), csw_n low for 20 cycles -> exactly one cpu_req with cpu_wrt = 1, cpu_adr = 16'h0001, cpu_dbo = 8'h81, pulse 6 ±1 cycles after the csw_n fall; cd_oe stays 0.
- Read: mode = 0, vdp_dbi = 8'h0F, csr_n low for 20 cycles -> one cpu_req with cpu_wrt = 0; rd_data = 8'h0F captured 4 cycles after the pulse; cd_o = 8'hF0; cd_oe goes high once the filter passes and low about 6 cycles after csr_n rises.
- Glitch rejection: csw_n low for 2 cycles, then high -> no cpu_req and the FSM stays in IDLE; csw_n low for 3+ cycles -> exactly one cpu_req.
- Simultaneous strobes: csr_n and csw_n fall together -> no cpu_req and err_both = 1; the next access after both rise works normally; err_clr -> err_both = 0.
- Back-to-back: 8 writes with 10-cycle low and 10-cycle high periods -> exactly 8 requests with no duplicates, and cpu_dbo tracks each data byte.
- Reset mid-read: assert reset while in RD_CAP with csr_n still low -> all outputs return to reset values; after release, no request is issued until csr_n has cycled high then low.
